menu_navigator: RTL

- Consumes the single-cycle left/right/select pulses produced by the button debouncer and turns them into a product cursor, a two-press purchase confirmation and a valid/ready request to the dispense controller.
- Sits between the debouncer and the vending dispense/payment logic.
- All logic runs on fastClk; input pulses are one fastClk cycle wide.

---
 rtl/menu_nav_pkg.sv | 27 ++
 rtl/menu_skip_search.sv | 38 +++
 rtl/menu_navigator.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/menu_nav_pkg.sv
`default_nettype none
// ============================================================================
// menu_nav_pkg : navigator state type, default timing and cursor wrap helpers
// Revision     : 1.0
// ============================================================================
package menu_nav_pkg;

    typedef enum logic [1:0] {
        BROWSE   = 2'd0,
        ARMED    = 2'd1,
        REQUEST  = 2'd2,
        COOLDOWN = 2'd3
    } nav_state_e;

    localparam logic [23:0] DEF_CONFIRM_TICKS  = 24'd5_000_000;
    localparam logic [15:0] DEF_COOLDOWN_TICKS = 16'd1000;

    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned num);
        return (idx + 32'd1 >= num) ? 32'd0 : idx + 32'd1;
    endfunction

    function automatic int unsigned prev_idx(input int unsigned idx, input int unsigned num);
        return (idx == 32'd0) ? num - 32'd1 : idx - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/menu_skip_search.sv
`default_nettype none
// ============================================================================
// menu_skip_search : finds the nearest available item in the move direction
// Revision         : 1.0
// ============================================================================
module menu_skip_search #(
    parameter int unsigned NUM_ITEMS = 8,
    parameter int unsigned IDX_W     = 4
) (
    input  logic [IDX_W-1:0]     cur_i,
    input  logic [NUM_ITEMS-1:0] soldOut_i,
    input  logic                 dirRight_i,
    output logic [IDX_W-1:0]     next_o
);

    int unsigned w_cand;
    logic        w_found;

    // Candidates at distance 1..NUM_ITEMS-1; the current item is never a target,
    // so a fully sold-out menu leaves the cursor where it is.
    always_comb begin
        next_o  = cur_i;
        w_found = 1'b0;
        w_cand  = 32'd0;
        for (int unsigned k = 1; k < NUM_ITEMS; k++) begin
            w_cand = dirRight_i ? (32'(cur_i) + k) % NUM_ITEMS
                                : (32'(cur_i) + NUM_ITEMS - k) % NUM_ITEMS;
            for (int unsigned j = 0; j < NUM_ITEMS; j++) begin
                if (!w_found && (j == w_cand) && !soldOut_i[j]) begin
                    w_found = 1'b1;
                    next_o  = IDX_W'(j);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/menu_navigator.sv
`default_nettype none
// ============================================================================
// menu_navigator : cursor, two-press purchase confirm and dispense handshake.
//                  MENU_NAV_SKIP_SOLDOUT_EN makes moves skip sold-out items.
// Revision       : 1.0
// ============================================================================
module menu_navigator
    import menu_nav_pkg::*;
#(
    parameter int unsigned NUM_ITEMS      = 8,
    parameter int unsigned IDX_W          = 4,
    parameter logic [23:0] CONFIRM_TICKS  = DEF_CONFIRM_TICKS,
    parameter logic [15:0] COOLDOWN_TICKS = DEF_COOLDOWN_TICKS
) (
    input  logic                 fastClk,
    input  logic                 rstN,
    input  logic                 leftSignal,
    input  logic                 rightSignal,
    input  logic                 selectSignal,
    input  logic [NUM_ITEMS-1:0] soldOut,
    input  logic                 reqReady,
    output logic [IDX_W-1:0]     cursor,
    output logic                 armed,
    output logic                 reqValid,
    output logic [IDX_W-1:0]     reqItem,
    output logic                 rejectPulse
);

    localparam int unsigned SPAN = 32'd1 << IDX_W;

    nav_state_e       state_q, state_d;
    logic [IDX_W-1:0] cursor_q, cursor_d;
    logic [IDX_W-1:0] reqItem_q, reqItem_d;
    logic             armed_q, armed_d;
    logic             reqValid_q, reqValid_d;
    logic             reject_q, reject_d;
    logic [23:0]      confirm_q, confirm_d;
    logic [15:0]      cool_q, cool_d;

    logic             w_moveRight, w_moveLeft, w_move;
    logic [IDX_W-1:0] w_moveIdx;
    logic [SPAN-1:0]  w_soldPad;
    logic             w_curSold;

    // Unused cursor codes read as sold out so they can never be armed.
    generate
        if (SPAN > NUM_ITEMS) begin : g_sold_pad
            assign w_soldPad = {{(SPAN - NUM_ITEMS){1'b1}}, soldOut};
        end else begin : g_sold_exact
            assign w_soldPad = soldOut;
        end
    endgenerate

    assign w_curSold   = w_soldPad[cursor_q];
    assign w_moveRight = rightSignal & ~leftSignal;
    assign w_moveLeft  = leftSignal & ~rightSignal;
    assign w_move      = w_moveRight | w_moveLeft;

`ifdef MENU_NAV_SKIP_SOLDOUT_EN
    menu_skip_search #(
        .NUM_ITEMS (NUM_ITEMS),
        .IDX_W     (IDX_W)
    ) u_skip (
        .cur_i      (cursor_q),
        .soldOut_i  (soldOut),
        .dirRight_i (w_moveRight),
        .next_o     (w_moveIdx)
    );
`else
    assign w_moveIdx = w_moveRight ? IDX_W'(next_idx(32'(cursor_q), NUM_ITEMS))
                                   : IDX_W'(prev_idx(32'(cursor_q), NUM_ITEMS));
`endif

    always_comb begin
        state_d    = state_q;
        cursor_d   = cursor_q;
        reqItem_d  = reqItem_q;
        reqValid_d = reqValid_q;
        reject_d   = 1'b0;
        confirm_d  = confirm_q;
        cool_d     = cool_q;

        case (state_q)
            BROWSE: begin
                if (w_move) begin
                    cursor_d = w_moveIdx;
                end else if (selectSignal) begin
                    if (w_curSold) begin
                        reject_d = 1'b1;
                    end else begin
                        state_d   = ARMED;
                        confirm_d = CONFIRM_TICKS;
                    end
                end
            end
            ARMED: begin
                // Priority: move, then a sold-out change, then confirm, then timeout.
                if (w_move) begin
                    cursor_d  = w_moveIdx;
                    state_d   = BROWSE;
                    confirm_d = 24'd0;
                end else if (w_curSold) begin
                    reject_d  = 1'b1;
                    state_d   = BROWSE;
                    confirm_d = 24'd0;
                end else if (selectSignal) begin
                    state_d    = REQUEST;
                    reqValid_d = 1'b1;
                    reqItem_d  = cursor_q;
                    confirm_d  = 24'd0;
                end else if (confirm_q <= 24'd1) begin
                    state_d   = BROWSE;
                    confirm_d = 24'd0;
                end else begin
                    confirm_d = confirm_q - 24'd1;
                end
            end
            REQUEST: begin
                if (reqValid_q && reqReady) begin
                    reqValid_d = 1'b0;
                    state_d    = COOLDOWN;
                    cool_d     = COOLDOWN_TICKS;
                end
            end
            COOLDOWN: begin
                if (cool_q <= 16'd1) begin
                    state_d = BROWSE;
                    cool_d  = 16'd0;
                end else begin
                    cool_d = cool_q - 16'd1;
                end
            end
            default: begin
                state_d = BROWSE;
            end
        endcase

        armed_d = (state_d == ARMED);
    end

    always_ff @(posedge fastClk) begin
        if (!rstN) begin
            state_q    <= BROWSE;
            cursor_q   <= '0;
            reqItem_q  <= '0;
            armed_q    <= 1'b0;
            reqValid_q <= 1'b0;
            reject_q   <= 1'b0;
            confirm_q  <= 24'd0;
            cool_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            reqItem_q  <= reqItem_d;
            armed_q    <= armed_d;
            reqValid_q <= reqValid_d;
            reject_q   <= reject_d;
            confirm_q  <= confirm_d;
            cool_q     <= cool_d;
        end
    end

    assign cursor      = cursor_q;
    assign armed       = armed_q;
    assign reqValid    = reqValid_q;
    assign reqItem     = reqItem_q;
    assign rejectPulse = reject_q;

endmodule
`default_nettype wire
